l2_dram_port: RTL and testbench

Sits directly downstream of the L2 MSHR and eviction logic and is the only L2 agent on the DRAM AXI4 bus. It turns L2 line-fill requests into AXI4 INCR read bursts, assembles the beats into a full cache line, and returns that line to the L2. It turns dirty-line writebacks into AXI4 write bursts, and blocks a fill to any line whose writeback is still in flight.

---
 rtl/l2_dram_port.sv | 178 +++++++++++++++++
 tb/tb_l2_dram_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_dram_port.sv
// rtl/l2_dram_port.sv - L2 line fills and dirty writebacks mapped onto AXI4 INCR bursts
module l2_dram_port #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 fill_req_valid,
    output logic                                 fill_req_ready,
    input  logic [ID_W+ADDR_W-1:0]               fill_req_pkt,
    output logic                                 fill_rsp_valid,
    input  logic                                 fill_rsp_ready,
    output logic [ID_W+1+8*LINE_BYTES-1:0]       fill_rsp_pkt,
    input  logic                                 wb_req_valid,
    output logic                                 wb_req_ready,
    input  logic [ADDR_W+8*LINE_BYTES-1:0]       wb_req_pkt,
    output logic                                 wb_done_valid,
    output logic                                 wb_done_err,
    output logic                                 ar_valid,
    input  logic                                 ar_ready,
    output logic [ADDR_W+12:0]                   ar_pkt,
    input  logic                                 r_valid,
    output logic                                 r_ready,
    input  logic [DATA_W+2:0]                    r_pkt,
    output logic                                 aw_valid,
    input  logic                                 aw_ready,
    output logic [ADDR_W+12:0]                   aw_pkt,
    output logic                                 w_valid,
    input  logic                                 w_ready,
    output logic [DATA_W+DATA_W/8:0]             w_pkt,
    input  logic                                 b_valid,
    output logic                                 b_ready,
    input  logic [1:0]                           b_resp
);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [12:0] BURST_ATTR = {8'(BEATS - 1), 3'($clog2(DATA_W / 8)), 2'b01};
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RSP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return a & ~OFF_MASK;
    endfunction

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic alive;
    logic [ID_W-1:0] fill_id;
    logic [ADDR_W-1:0] fill_addr, wb_addr;
    logic [BEATS-1:0][DATA_W-1:0] rd_line, wb_line;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic r_err, aw_done, w_sent;
    logic fill_fire, wb_fire, hazard, aw_fire, w_fire, w_last_fire;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    // A writeback accepted this cycle counts as in flight, so it wins a same-line race.
    always_comb begin
        wb_req_ready   = alive && (w_state == W_IDLE);
        wb_fire        = wb_req_valid && wb_req_ready;
        hazard         = ((w_state != W_IDLE) && (line_addr(fill_req_pkt[ADDR_W-1:0]) == wb_addr)) ||
                         (wb_fire && (line_addr(fill_req_pkt[ADDR_W-1:0]) ==
                                      line_addr(wb_req_pkt[ADDR_W+LINE_W-1:LINE_W])));
        fill_req_ready = alive && (r_state == R_IDLE) && !hazard;
        fill_fire      = fill_req_valid && fill_req_ready;
        aw_fire        = aw_valid && aw_ready;
        w_fire         = w_valid && w_ready;
        w_last_fire    = w_fire && (w_cnt == LAST_BEAT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (fill_fire) r_next = R_ADDR;
            R_ADDR:  if (ar_ready) r_next = R_DATA;
            R_DATA:  if (r_valid && (r_cnt == LAST_BEAT)) r_next = R_RSP;
            R_RSP:   if (fill_rsp_ready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        ar_valid       = (r_state == R_ADDR);
        r_ready        = (r_state == R_DATA);
        fill_rsp_valid = (r_state == R_RSP);
        ar_pkt         = ar_valid ? {fill_addr, BURST_ATTR} : '0;
        fill_rsp_pkt   = {fill_id, r_err, rd_line};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_id   <= '0;
            fill_addr <= '0;
            rd_line   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (fill_fire) begin
                fill_id   <= fill_req_pkt[ID_W+ADDR_W-1:ADDR_W];
                fill_addr <= line_addr(fill_req_pkt[ADDR_W-1:0]);
                r_cnt     <= '0;
                r_err     <= 1'b0;
            end
            if (r_valid && r_ready) begin
                rd_line[r_cnt] <= r_pkt[DATA_W+2:3];
                r_cnt          <= r_cnt + 1'b1;
                if ((r_pkt[2:1] != 2'b00) || (r_pkt[0] != (r_cnt == LAST_BEAT)))
                    r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // AW and W finish in either order; the state moves on once both have.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (wb_fire) w_next = W_BUSY;
            W_BUSY:  if ((aw_done || aw_fire) && (w_sent || w_last_fire)) w_next = W_RESP;
            W_RESP:  if (b_valid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        aw_valid = (w_state == W_BUSY) && !aw_done;
        w_valid  = (w_state == W_BUSY) && !w_sent;
        b_ready  = (w_state == W_RESP);
        aw_pkt   = aw_valid ? {wb_addr, BURST_ATTR} : '0;
        w_pkt    = w_valid ? {wb_line[w_cnt], {(DATA_W/8){1'b1}}, (w_cnt == LAST_BEAT)} : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_addr       <= '0;
            wb_line       <= '0;
            w_cnt         <= '0;
            aw_done       <= 1'b0;
            w_sent        <= 1'b0;
            wb_done_valid <= 1'b0;
            wb_done_err   <= 1'b0;
        end else begin
            if (wb_fire) begin
                wb_addr <= line_addr(wb_req_pkt[ADDR_W+LINE_W-1:LINE_W]);
                wb_line <= wb_req_pkt[LINE_W-1:0];
                w_cnt   <= '0;
                aw_done <= 1'b0;
                w_sent  <= 1'b0;
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire) begin
                w_cnt <= w_cnt + 1'b1;
                if (w_last_fire) w_sent <= 1'b1;
            end
            wb_done_valid <= b_valid && b_ready;
            wb_done_err   <= b_valid && b_ready && (b_resp != 2'b00);
        end
    end
endmodule

// File: tb/tb_l2_dram_port.sv
// tb/tb_l2_dram_port.sv - directed self-checking bench for l2_dram_port
module tb_l2_dram_port;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic fill_req_valid = 0, fill_req_ready;
    logic [34:0] fill_req_pkt = '0;
    logic fill_rsp_valid, fill_rsp_ready = 0;
    logic [515:0] fill_rsp_pkt;
    logic wb_req_valid = 0, wb_req_ready;
    logic [543:0] wb_req_pkt = '0;
    logic wb_done_valid, wb_done_err;
    logic ar_valid, ar_ready = 0;
    logic [44:0] ar_pkt;
    logic r_valid = 0, r_ready;
    logic [66:0] r_pkt = '0;
    logic aw_valid, aw_ready = 0;
    logic [44:0] aw_pkt;
    logic w_valid, w_ready = 0;
    logic [72:0] w_pkt;
    logic b_valid = 0, b_ready;
    logic [1:0] b_resp = 0;

    int errors = 0;
    int checks = 0;
    logic [511:0] line_a, line_b, line_c, line_d;
    logic [688:0] all_out;

    l2_dram_port dut (
        .clock(clock), .reset(reset),
        .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready), .fill_req_pkt(fill_req_pkt),
        .fill_rsp_valid(fill_rsp_valid), .fill_rsp_ready(fill_rsp_ready), .fill_rsp_pkt(fill_rsp_pkt),
        .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready), .wb_req_pkt(wb_req_pkt),
        .wb_done_valid(wb_done_valid), .wb_done_err(wb_done_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_pkt(ar_pkt),
        .r_valid(r_valid), .r_ready(r_ready), .r_pkt(r_pkt),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_pkt(aw_pkt),
        .w_valid(w_valid), .w_ready(w_ready), .w_pkt(w_pkt),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    always #5 clock = ~clock;

    assign all_out = {fill_req_ready, fill_rsp_valid, fill_rsp_pkt, wb_req_ready, wb_done_valid,
                      wb_done_err, ar_valid, ar_pkt, r_ready, aw_valid, aw_pkt, w_valid, w_pkt, b_ready};

    task automatic chk(input string tag, input logic [699:0] obs, input logic [699:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in R_ADDR on a negedge; leaves one cycle after the fill response handshake.
    task automatic read_phase(input logic [2:0] id, input logic [31:0] addr, input int ar_delay,
                              input int gaps, input int err_beat, input logic [63:0] base,
                              input int rsp_delay);
        logic [511:0] exp_line;
        for (int c = 0; c <= ar_delay; c++) begin
            ar_ready = (c == ar_delay);
            #1;
            chk("ar_valid", ar_valid, 1'b1);
            chk("ar_pkt", ar_pkt, {addr & 32'hFFFF_FFC0, 8'd7, 3'd3, 2'b01});
            chk("fill_rdy_busy", fill_req_ready, 1'b0);
            @(negedge clock);
        end
        ar_ready = 0;
        for (int k = 0; k < 8; k++) begin
            if (gaps != 0 && k[0]) begin
                r_valid = 0;
                #1;
                chk("r_ready_gap", r_ready, 1'b1);
                @(negedge clock);
            end
            r_valid = 1;
            r_pkt = {base * 64'(k), (k == err_beat) ? 2'b10 : 2'b00, k == 7};
            #1;
            chk("r_ready", r_ready, 1'b1);
            chk("ar_valid_low", ar_valid, 1'b0);
            exp_line[k*64 +: 64] = base * 64'(k);
            @(negedge clock);
        end
        r_valid = 0;
        for (int c = 0; c <= rsp_delay; c++) begin
            fill_rsp_ready = (c == rsp_delay);
            #1;
            chk("fill_rsp_valid", fill_rsp_valid, 1'b1);
            chk("fill_rsp_pkt", fill_rsp_pkt, {id, (err_beat < 8) ? 1'b1 : 1'b0, exp_line});
            chk("fill_rdy_rsp", fill_req_ready, 1'b0);
            @(negedge clock);
        end
        fill_rsp_ready = 0;
        #1;
        chk("fill_rsp_valid_drop", fill_rsp_valid, 1'b0);
        chk("fill_rdy_after_rsp", fill_req_ready, 1'b1);
        @(negedge clock);
    endtask

    // Entered in W_BUSY on a negedge; the bench tracks AW/W completion itself.
    task automatic wb_phase(input logic [31:0] addr, input logic [511:0] line, input int aw_delay,
                            input int w_alt, input int b_delay, input logic [1:0] bresp,
                            input logic exp_frdy);
        logic aw_taken;
        int sent;
        aw_taken = 0;
        sent = 0;
        for (int c = 0; c < 40 && !(aw_taken && sent == 8); c++) begin
            aw_ready = (c >= aw_delay);
            w_ready = (w_alt != 0) ? c[0] : 1'b1;
            #1;
            chk("aw_valid", aw_valid, !aw_taken);
            if (!aw_taken) chk("aw_pkt", aw_pkt, {addr, 8'd7, 3'd3, 2'b01});
            chk("w_valid", w_valid, sent < 8);
            if (sent < 8) chk("w_pkt", w_pkt, {line[sent*64 +: 64], 8'hFF, sent == 7});
            chk("wb_rdy_busy", wb_req_ready, 1'b0);
            chk("fill_rdy_wbusy", fill_req_ready, exp_frdy);
            if (aw_ready && !aw_taken) aw_taken = 1;
            if (w_ready && sent < 8) sent++;
            @(negedge clock);
        end
        aw_ready = 0;
        w_ready = 0;
        chk("wr_bound", aw_taken && sent == 8, 1'b1);
        for (int c = 0; c <= b_delay; c++) begin
            b_valid = (c == b_delay);
            b_resp = bresp;
            #1;
            chk("b_ready", b_ready, 1'b1);
            chk("aw_w_idle", {aw_valid, w_valid}, 2'b00);
            chk("fill_rdy_wresp", fill_req_ready, exp_frdy);
            chk("wb_done_early", wb_done_valid, 1'b0);
            @(negedge clock);
        end
        b_valid = 0;
        b_resp = 0;
        #1;
        chk("wb_done_valid", wb_done_valid, 1'b1);
        chk("wb_done_err", wb_done_err, bresp != 2'b00);
        chk("b_ready_drop", b_ready, 1'b0);
        chk("fill_rdy_after_b", fill_req_ready, 1'b1);
        chk("wb_rdy_after_b", wb_req_ready, 1'b1);
        @(negedge clock);
        #1;
        chk("wb_done_pulse", wb_done_valid, 1'b0);
        @(negedge clock);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            line_a[k*64 +: 64] = 64'h0101_0101_0101_0101 * 64'(k + 1);
            line_b[k*64 +: 64] = ~(64'h0101_0101_0101_0101 * 64'(k + 1));
            line_c[k*64 +: 64] = {32'hC0DE_0000 + 32'(k), 32'h1234_5678};
            line_d[k*64 +: 64] = {32'hDEAD_0000 + 32'(k), 32'h0};
        end
        #2 reset = 0;
        @(negedge clock);
        #1;
        chk("reset_outputs", all_out, '0);
        @(negedge clock);
        reset = 1;
        #1;
        chk("ready_before_edge", {fill_req_ready, wb_req_ready}, 2'b00);
        @(negedge clock);
        #1;
        chk("ready_after_edge", {fill_req_ready, wb_req_ready}, 2'b11);

        // Fill 0x1234 id 5: late AR, R gaps, late response consumer.
        fill_req_pkt = {3'd5, 32'h0000_1234};
        fill_req_valid = 1;
        #1;
        chk("fill1_accept", fill_req_ready, 1'b1);
        @(negedge clock);
        fill_req_valid = 0;
        read_phase(3'd5, 32'h1234, 4, 1, 99, 64'h1111, 5);

        // Writeback 0x4000: AW late by 3, W ready alternating, OKAY.
        fill_req_pkt = {3'd0, 32'h0000_8000};
        wb_req_pkt = {32'h0000_4000, line_a};
        wb_req_valid = 1;
        #1;
        chk("wb1_accept", wb_req_ready, 1'b1);
        @(negedge clock);
        wb_req_valid = 0;
        wb_phase(32'h4000, line_a, 3, 1, 1, 2'b00, 1'b1);

        // Writeback 0x2000 with fill 0x2010 pending; AW and last W coincide; DECERR.
        fill_req_pkt = {3'd6, 32'h0000_2010};
        wb_req_pkt = {32'h0000_2000, line_c};
        wb_req_valid = 1;
        #1;
        chk("wb2_accept", wb_req_ready, 1'b1);
        chk("hazard_same_cycle", fill_req_ready, 1'b0);
        @(negedge clock);
        wb_req_valid = 0;
        wb_phase(32'h2000, line_c, 7, 0, 2, 2'b11, 1'b0);

        // Same-line race: writeback wins; a different-line fill then proceeds, SLVERR on beat 3.
        wb_req_pkt = {32'h0000_6000, line_b};
        wb_req_valid = 1;
        fill_req_pkt = {3'd4, 32'h0000_6008};
        fill_req_valid = 1;
        #1;
        chk("race_wb_ready", wb_req_ready, 1'b1);
        chk("race_fill_ready", fill_req_ready, 1'b0);
        @(negedge clock);
        wb_req_valid = 0;
        fill_req_pkt = {3'd2, 32'h0000_3000};
        #1;
        chk("concurrent_fill_ready", fill_req_ready, 1'b1);
        @(negedge clock);
        fill_req_valid = 0;
        read_phase(3'd2, 32'h3000, 0, 0, 3, 64'h0F0F, 0);
        wb_phase(32'h6000, line_b, 0, 0, 0, 2'b00, 1'b1);

        // Reset in the middle of a read with a writeback pending.
        fill_req_pkt = {3'd1, 32'h0000_9000};
        fill_req_valid = 1;
        wb_req_pkt = {32'h0000_A000, line_d};
        wb_req_valid = 1;
        #1;
        chk("pre_rst_accept", {fill_req_ready, wb_req_ready}, 2'b11);
        @(negedge clock);
        fill_req_valid = 0;
        wb_req_valid = 0;
        ar_ready = 1;
        @(negedge clock);
        ar_ready = 0;
        for (int k = 0; k < 5; k++) begin
            r_valid = 1;
            r_pkt = {64'h5555 * 64'(k), 2'b00, 1'b0};
            #1;
            chk("pre_rst_r_ready", r_ready, 1'b1);
            if (k < 4) @(negedge clock);
        end
        chk("pre_rst_aw_valid", aw_valid, 1'b1);
        reset = 0;
        #1;
        chk("async_reset_outputs", all_out, '0);
        r_valid = 0;
        r_pkt = '0;
        @(negedge clock);
        reset = 1;
        #1;
        chk("post_rst_ready_low", {fill_req_ready, wb_req_ready}, 2'b00);
        @(negedge clock);
        #1;
        chk("post_rst_ready_high", {fill_req_ready, wb_req_ready}, 2'b11);
        chk("post_rst_idle", {aw_valid, w_valid, ar_valid, r_ready}, 4'b0000);
        fill_req_pkt = {3'd3, 32'h0000_0040};
        fill_req_valid = 1;
        @(negedge clock);
        fill_req_valid = 0;
        read_phase(3'd3, 32'h40, 1, 1, 99, 64'h2222, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
